// File: rtl/uart_rx_if.sv
// Receive-side bus of the UART: serial line and frame options in, received byte out.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_in;
  logic [1:0]            brg_select;
  logic                  rx_parity_per_byte;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_error;

  modport master (
    output rx_in, brg_select, rx_parity_per_byte,
    input  rx_valid, rx_data, rx_error
  );

  modport slave (
    input  rx_in, brg_select, rx_parity_per_byte,
    output rx_valid, rx_data, rx_error
  );
endinterface

// File: rtl/uart_rx.sv
// UART receive engine: 2-flop synchronised line, mid-bit sampling at N clocks per bit,
// optional even parity, one-cycle rx_valid strobe with held data and error.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic     clk_576KHz,
  input  logic     rst_n,
  uart_rx_if.slave rx_bus
);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic                  rx_meta;
  logic                  rx_s;
  logic                  rx_s_d;
  logic [5:0]            cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [1:0]            brg_reg;
  logic                  par_en_reg;
  logic                  par_err;

  function automatic logic [5:0] bit_m1(input logic [1:0] sel);
    case (sel)
      2'b00:   return 6'd59;
      2'b01:   return 6'd29;
      2'b10:   return 6'd14;
      default: return 6'd9;
    endcase
  endfunction

  // floor(N/2)-1: first expiry lands in the middle of the start bit
  function automatic logic [5:0] half_m1(input logic [1:0] sel);
    case (sel)
      2'b00:   return 6'd29;
      2'b01:   return 6'd14;
      2'b10:   return 6'd6;
      default: return 6'd4;
    endcase
  endfunction

  always_ff @(posedge clk_576KHz or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx_bus.rx_in;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  always_ff @(posedge clk_576KHz or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      bit_cnt            <= '0;
      shift_reg          <= '0;
      brg_reg            <= '0;
      par_en_reg         <= 1'b0;
      par_err            <= 1'b0;
      rx_bus.rx_valid    <= 1'b0;
      rx_bus.rx_data     <= '0;
      rx_bus.rx_error    <= 1'b0;
    end else begin
      rx_bus.rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Only a fresh 1->0 edge arms the receiver, so a held break never re-triggers
          if (rx_s_d && !rx_s) begin
            brg_reg    <= rx_bus.brg_select;
            par_en_reg <= rx_bus.rx_parity_per_byte;
            cnt        <= half_m1(rx_bus.brg_select);
            bit_cnt    <= '0;
            par_err    <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (cnt == 6'd0) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              cnt   <= bit_m1(brg_reg);
              state <= DATA;
            end
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        DATA: begin
          if (cnt == 6'd0) begin
            shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt   <= bit_cnt + BW'(1);
            cnt       <= bit_m1(brg_reg);
            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
              state <= par_en_reg ? PARITY : STOP;
            end
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        PARITY: begin
          if (cnt == 6'd0) begin
            par_err <= (^shift_reg) ^ rx_s;
            cnt     <= bit_m1(brg_reg);
            state   <= STOP;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        STOP: begin
          if (cnt == 6'd0) begin
            rx_bus.rx_data  <= shift_reg;
            rx_bus.rx_error <= par_err | ~rx_s;
            rx_bus.rx_valid <= 1'b1;
            state           <= IDLE;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed frames for uart_rx, checked against a frame-level reference
// model (expected byte, error flag and strobe latency computed from the frame contents).
module tb_uart_rx;
  localparam int DW = 8;

  logic clk_576KHz = 1'b0;
  logic rst_n      = 1'b0;

  uart_rx_if #(.DATA_WIDTH(DW)) rx_bus ();

  uart_rx #(.DATA_WIDTH(DW)) dut (
    .clk_576KHz (clk_576KHz),
    .rst_n      (rst_n),
    .rx_bus     (rx_bus)
  );

  always #5 clk_576KHz = ~clk_576KHz;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    longint        fall;
    longint        lat;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  longint cyc          = 0;
  int     n_compared   = 0;
  int     n_mismatched = 0;
  int     n_strobes    = 0;
  int     n_frames     = 0;

  always @(posedge clk_576KHz) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int bit_clocks(input logic [1:0] sel);
    case (sel)
      2'b00:   return 60;
      2'b01:   return 30;
      2'b10:   return 15;
      default: return 10;
    endcase
  endfunction

  // Scoreboard: every strobe must match the oldest frame still outstanding
  always @(negedge clk_576KHz) begin
    if (rst_n && rx_bus.rx_valid === 1'b1) begin
      n_strobes++;
      if (exp_q.size() == 0) begin
        check_value("spurious_strobe", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_value("rx_data", rx_bus.rx_data, mon_e.data);
        check_value("rx_error", rx_bus.rx_error, mon_e.err);
        check_value("latency", cyc - mon_e.fall, mon_e.lat);
        $display("frame data=%02h err=%0b latency=%0d", rx_bus.rx_data, rx_bus.rx_error, cyc - mon_e.fall);
      end
    end
  end

  task automatic drive(input logic b, input int cycles);
    rx_bus.rx_in = b;
    repeat (cycles) @(posedge clk_576KHz);
    #1;
  endtask

  // Line changes one step after a clock edge, so the edge reaches rx_s two cycles later
  // and the strobe follows the stop sample: latency = 2 + N/2 + N*(DW+1+P) + 1.
  task automatic send_frame(input logic [DW-1:0] data, input logic [1:0] brg, input bit par_en,
                            input bit pbit, input bit stop_bit, input bit tail_level,
                            input int tail_cycles, input bit chg_brg);
    int   n;
    exp_t e;
    n = bit_clocks(brg);
    rx_bus.brg_select         = brg;
    rx_bus.rx_parity_per_byte = par_en;
    e.data = data;
    e.err  = (par_en && (((^data) ^ pbit) != 1'b0)) || !stop_bit;
    e.fall = cyc;
    e.lat  = 3 + n / 2 + n * (DW + 1 + (par_en ? 1 : 0));
    exp_q.push_back(e);
    n_frames++;
    drive(1'b0, n);
    for (int i = 0; i < DW; i++) begin
      drive(data[i], n);
      if (chg_brg && i == 3) begin
        rx_bus.brg_select         = 2'b11;
        rx_bus.rx_parity_per_byte = ~par_en;
      end
    end
    if (par_en) drive(pbit, n);
    drive(stop_bit, n);
    if (tail_cycles > 0) drive(tail_level, tail_cycles);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          s0;
    logic [DW-1:0] d;
    logic [1:0]  brg;
    bit          par, pbit, stop, chg;
    int          tail;

    rx_bus.rx_in              = 1'b1;
    rx_bus.brg_select         = 2'b00;
    rx_bus.rx_parity_per_byte = 1'b0;
    repeat (3) @(posedge clk_576KHz);
    #1;
    check_value("reset_valid", rx_bus.rx_valid, 0);
    check_value("reset_data", rx_bus.rx_data, 0);
    check_value("reset_error", rx_bus.rx_error, 0);
    rst_n = 1'b1;
    drive(1'b1, 5);

    send_frame(8'hA5, 2'b00, 0, 0, 1, 1, 10, 0);
    send_frame(8'hFC, 2'b00, 1, 0, 1, 1, 10, 0);
    send_frame(8'hFC, 2'b00, 1, 1, 1, 1, 10, 0);

    // Framing error followed by a 5-bit-time break
    s0 = n_strobes;
    send_frame(8'h3C, 2'b00, 0, 0, 0, 0, 300, 0);
    drive(1'b1, 200);
    check_value("break_strobes", n_strobes - s0, 1);
    send_frame(8'h11, 2'b00, 0, 0, 1, 1, 10, 0);

    // 20-cycle glitch at 9600 must not start a frame
    s0 = n_strobes;
    drive(1'b0, 20);
    drive(1'b1, 100);
    check_value("glitch_strobes", n_strobes - s0, 0);
    send_frame(8'h55, 2'b00, 0, 0, 1, 1, 10, 0);

    // Back-to-back at 57600 with exactly one stop bit
    send_frame(8'h01, 2'b11, 0, 0, 1, 1, 0, 0);
    send_frame(8'h80, 2'b11, 0, 0, 1, 1, 0, 0);
    send_frame(8'hFF, 2'b11, 0, 0, 1, 1, 30, 0);

    // Reset in the middle of the data bits of 0xA5
    s0 = n_strobes;
    rx_bus.brg_select = 2'b00;
    rx_bus.rx_parity_per_byte = 1'b0;
    drive(1'b0, 60);
    drive(1'b1, 60);
    drive(1'b0, 60);
    drive(1'b1, 30);
    rst_n = 1'b0;
    repeat (2) @(posedge clk_576KHz);
    #1;
    check_value("midrst_valid", rx_bus.rx_valid, 0);
    check_value("midrst_data", rx_bus.rx_data, 0);
    check_value("midrst_error", rx_bus.rx_error, 0);
    rst_n = 1'b1;
    drive(1'b1, 700);
    check_value("midrst_strobes", n_strobes - s0, 0);
    send_frame(8'h5A, 2'b00, 0, 0, 1, 1, 10, 0);

    // Options changed mid-frame must not affect the frame in flight
    send_frame(8'hC3, 2'b00, 0, 0, 1, 1, 20, 1);
    send_frame(8'h96, 2'b00, 1, 0, 1, 1, 20, 1);

    for (int i = 0; i < 24; i++) begin
      d    = DW'($urandom);
      brg  = 2'($urandom_range(0, 3));
      par  = 1'($urandom_range(0, 1));
      pbit = par ? ((^d) ^ ($urandom_range(0, 3) == 0)) : 1'b0;
      stop = ($urandom_range(0, 4) != 0);
      chg  = ($urandom_range(0, 5) == 0);
      tail = $urandom_range(0, 40);
      if (!stop && tail < 2) tail = 2;
      send_frame(d, brg, par, pbit, stop, 1, tail, chg);
    end
    drive(1'b1, 5);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk_576KHz);
    #1;
    check_value("drain", exp_q.size(), 0);
    check_value("strobe_total", n_strobes, n_frames);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
